instr_fetch: RTL and testbench

Upstream stage of the microsequencer (mSeq). It holds the program counter and fetches one instruction word from memory per request, using a read/ready handshake. The fetched word is latched in an instruction register, and the opcode field is presented to mSeq's opcode input. A fetch starts when the sequencer raises its "fetch next" control bit.

---
 rtl/instr_fetch.sv | 59 +++++
 tb/tb_instr_fetch.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: program counter plus single-outstanding instruction fetch feeding the microsequencer
module instr_fetch #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int OPCODE_WIDTH = 2,
  parameter int OPCODE_LSB = 6,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic clock,
  input  logic reset,
  input  logic fetch,
  input  logic pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_value,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic mem_read,
  input  logic mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [OPCODE_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0] operand,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic ir_valid,
  output logic busy
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] ir;
  logic [ADDR_WIDTH-1:0] target;
  assign target = pc_load ? pc_load_value : pc;
  assign opcode = ir[OPCODE_LSB +: OPCODE_WIDTH];
  assign operand = ir;
  assign busy = state == REQ;
  // fetch sequencing: issue a read from IDLE, hold it in REQ until memory answers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      ir <= '0;
      ir_valid <= 1'b0;
      mem_read <= 1'b0;
      mem_addr <= '0;
    end else if (state == IDLE) begin
      if (fetch) begin
        mem_addr <= target;
        pc <= target;
        mem_read <= 1'b1;
        ir_valid <= 1'b0;
        state <= REQ;
      end else if (pc_load) begin
        pc <= pc_load_value;
      end
    end else if (mem_ready) begin
      ir <= mem_data;
      pc <= mem_addr + ADDR_WIDTH'(1);
      ir_valid <= 1'b1;
      mem_read <= 1'b0;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized fetch traffic checked by a queue-based scoreboard and monitor
module tb_instr_fetch;
  logic clock = 0;
  logic reset = 1;
  logic fetch = 0;
  logic pc_load = 0;
  logic [7:0] pc_load_value = 0;
  logic [7:0] mem_addr;
  logic mem_read;
  logic mem_ready = 0;
  logic [7:0] mem_data = 0;
  logic [1:0] opcode;
  logic [7:0] operand;
  logic [7:0] pc;
  logic ir_valid;
  logic busy;

  instr_fetch dut (
    .clock(clock), .reset(reset), .fetch(fetch), .pc_load(pc_load),
    .pc_load_value(pc_load_value), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_ready(mem_ready), .mem_data(mem_data), .opcode(opcode), .operand(operand),
    .pc(pc), .ir_valid(ir_valid), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] next_pc;
  } exp_t;

  exp_t sb[$];
  logic [7:0] mem [256];
  logic [7:0] mpc = 0;
  int vectors = 0;
  int miscompares = 0;
  bit hold = 0;
  bit force_ready = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // memory model: random wait states, stray ready pulses while idle
  int wl = -1;
  always @(negedge clock) begin
    if (reset || hold) begin
      mem_ready = force_ready;
      mem_data = 8'hFF;
      wl = -1;
    end else if (mem_read) begin
      if (wl < 0) wl = $urandom_range(0, 3);
      if (wl == 0) begin
        mem_ready = 1;
        mem_data = mem[mem_addr];
        wl = -1;
      end else begin
        mem_ready = 0;
        mem_data = 8'($urandom);
        wl--;
      end
    end else begin
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_data = 8'($urandom);
      wl = -1;
    end
  end

  // monitor: compares DUT behaviour at every edge against the scoreboard
  logic m_rs, m_hs, m_pr;
  logic [7:0] m_pa, m_pop;
  logic exp_valid = 0;
  exp_t e;
  always @(posedge clock) begin
    m_rs = reset;
    m_hs = mem_read && mem_ready && !reset;
    m_pr = mem_read;
    m_pa = mem_addr;
    m_pop = operand;
    #1;
    if (m_rs) begin
      sb.delete();
      exp_valid = 0;
    end else begin
      if (m_hs) begin
        if (sb.size() == 0) chk("unexpected_completion", 1, 0);
        else begin
          e = sb.pop_front();
          chk("operand", operand, e.data);
          chk("opcode", opcode, e.data[7:6]);
          chk("pc_after", pc, e.next_pc);
          exp_valid = 1;
        end
      end else begin
        chk("ir_hold", operand, m_pop);
        if (m_pr && mem_read) chk("addr_stable", mem_addr, m_pa);
      end
      if (sb.size() != 0) exp_valid = 0;
      if (!m_pr && mem_read && sb.size() != 0) chk("mem_addr", mem_addr, sb[0].addr);
      chk("busy", busy, sb.size() != 0);
      chk("mem_read", mem_read, sb.size() != 0);
      chk("ir_valid", ir_valid, exp_valid);
    end
  end

  task automatic issue(input bit j, input logic [7:0] t);
    logic [7:0] a;
    int n;
    @(negedge clock);
    fetch = 1;
    pc_load = j;
    pc_load_value = t;
    a = j ? t : mpc;
    sb.push_back('{a, mem[a], a + 8'd1});
    mpc = a + 8'd1;
    n = 0;
    forever begin
      @(negedge clock);
      if (sb.size() == 0 || n >= 30) break;
      fetch = 1'($urandom);
      pc_load = 1'($urandom);
      pc_load_value = 8'($urandom);
      n++;
    end
    fetch = 0;
    pc_load = 0;
    if (sb.size() != 0) begin
      chk("fetch_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic load(input logic [7:0] t);
    @(negedge clock);
    pc_load = 1;
    pc_load_value = t;
    mpc = t;
    @(negedge clock);
    pc_load = 0;
    chk("pc_load", pc, t);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'hC5;
    mem[8'h01] = 8'h40;
    mem[8'h20] = 8'h80;
    repeat (3) @(negedge clock);
    chk("rst_pc", pc, 0);
    chk("rst_operand", operand, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_busy", busy, 0);
    reset = 0;
    issue(0, 0);
    issue(0, 0);
    issue(1, 8'h20);
    load(8'hFF);
    issue(0, 0);
    chk("wrap_pc", pc, 0);
    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 3))
        0: issue(0, 0);
        1: issue(1, ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom));
        2: load(8'($urandom));
        default: @(negedge clock);
      endcase
    end
    @(negedge clock);
    hold = 1;
    fetch = 1;
    sb.push_back('{mpc, mem[mpc], mpc + 8'd1});
    @(negedge clock);
    fetch = 0;
    repeat (2) @(negedge clock);
    chk("req_mem_read", mem_read, 1);
    chk("req_busy", busy, 1);
    reset = 1;
    @(negedge clock);
    reset = 0;
    mpc = 0;
    chk("abort_mem_read", mem_read, 0);
    chk("abort_busy", busy, 0);
    chk("abort_pc", pc, 0);
    chk("abort_operand", operand, 0);
    force_ready = 1;
    @(negedge clock);
    force_ready = 0;
    @(negedge clock);
    chk("late_ready_operand", operand, 0);
    chk("late_ready_ir_valid", ir_valid, 0);
    hold = 0;
    issue(0, 0);
    repeat (2) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
